m107_int_ack_seq: RTL and testbench

CPU-side interrupt acknowledge sequencer for the M107 main board. It sits between the interrupt controller (`int_req`, `int_ack` and `int_vector`) and the V33 core's interrupt entry logic. When the CPU can accept an interrupt, it generates the two-pulse INTA bus sequence the controller expects and captures the 8-bit vector. It then hands the vector to the CPU through a valid/ready handshake.

---
 rtl/m107_pkg.sv | 23 ++
 rtl/m107_int_ack_seq.sv | 127 ++++++++++++
 tb/tb_m107_int_ack_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/m107_pkg.sv
// Shared M107 board types: interrupt-acknowledge sequencer state encoding and helpers.
package m107_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK1    = 3'd1,
        GAP     = 3'd2,
        ACK2    = 3'd3,
        DELIVER = 3'd4
    } inta_state_t;

    localparam int unsigned VEC_W = 8;

    // Width of a down-counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/m107_int_ack_seq.sv
// CPU-side INTA sequencer: issues the two-pulse acknowledge, captures the vector, hands it over via valid/ready.
// Optional abort on dropped int_req during GAP when M107_INTA_ABORT_EN is defined.
module m107_int_ack_seq
    import m107_pkg::*;
#(
    parameter int unsigned ACK_WIDTH = 2,
    parameter int unsigned ACK_GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             int_req,
    input  logic [VEC_W-1:0] int_vector,
    output logic             int_ack,
    input  logic             cpu_if,
    input  logic             cpu_boundary,
    output logic             cpu_int_take,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid,
`ifdef M107_INTA_ABORT_EN
    output logic             spurious,
`endif
    input  logic             vec_ready
);

    localparam int unsigned CNT_MAX = max_u(ACK_WIDTH, ACK_GAP);
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] WIDTH_LOAD = CNT_W'(ACK_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(ACK_GAP - 1);

    inta_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Sequencer: every transition and output update is qualified by ce; reset is not.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            int_ack      <= 1'b0;
            cpu_int_take <= 1'b0;
            vec          <= '0;
            vec_valid    <= 1'b0;
`ifdef M107_INTA_ABORT_EN
            spurious     <= 1'b0;
`endif
        end else if (ce) begin
`ifdef M107_INTA_ABORT_EN
            spurious <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (int_req && cpu_if && cpu_boundary) begin
                        state        <= ACK1;
                        int_ack      <= 1'b1;
                        cpu_int_take <= 1'b1;
                        cnt          <= WIDTH_LOAD;
                    end
                end

                ACK1: begin
                    if (cnt_zero) begin
                        state   <= GAP;
                        int_ack <= 1'b0;
                        cnt     <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt_zero) begin
`ifdef M107_INTA_ABORT_EN
                        // Controller withdrew the request: abandon without a second pulse.
                        if (!int_req) begin
                            state        <= IDLE;
                            cpu_int_take <= 1'b0;
                            spurious     <= 1'b1;
                        end else begin
                            state   <= ACK2;
                            int_ack <= 1'b1;
                            cnt     <= WIDTH_LOAD;
                        end
`else
                        state   <= ACK2;
                        int_ack <= 1'b1;
                        cnt     <= WIDTH_LOAD;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ACK2: begin
                    if (cnt_zero) begin
                        state     <= DELIVER;
                        int_ack   <= 1'b0;
                        vec       <= int_vector;
                        vec_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DELIVER: begin
                    // Restart is deliberately not checked here; earliest retrigger is the next ce edge.
                    if (vec_ready) begin
                        state        <= IDLE;
                        vec_valid    <= 1'b0;
                        cpu_int_take <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    int_ack      <= 1'b0;
                    cpu_int_take <= 1'b0;
                    vec_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m107_int_ack_seq.sv
// Directed bench for m107_int_ack_seq with default parameters; abort case compiled when M107_INTA_ABORT_EN is defined.
module tb_m107_int_ack_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       int_req;
    logic [7:0] int_vector;
    logic       int_ack;
    logic       cpu_if;
    logic       cpu_boundary;
    logic       cpu_int_take;
    logic [7:0] vec;
    logic       vec_valid;
    logic       vec_ready;
`ifdef M107_INTA_ABORT_EN
    logic       spurious;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m107_int_ack_seq dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .int_req      (int_req),
        .int_vector   (int_vector),
        .int_ack      (int_ack),
        .cpu_if       (cpu_if),
        .cpu_boundary (cpu_boundary),
        .cpu_int_take (cpu_int_take),
        .vec          (vec),
        .vec_valid    (vec_valid),
`ifdef M107_INTA_ABORT_EN
        .spurious     (spurious),
`endif
        .vec_ready    (vec_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clk edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sequence with ce=1 and vec_ready=1: trigger at E0, check pattern through E7.
    task automatic run_sequence(input logic [7:0] v, input string tag);
        logic [5:0] ack_pat;
        ack_pat = 6'b110011;
        int_req      = 1'b1;
        cpu_if       = 1'b1;
        vec_ready    = 1'b1;
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        int_vector   = v;
        check({tag, "_take_e0"}, 32'(cpu_int_take), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            check($sformatf("%s_ack_e%0d", tag, i), 32'(int_ack), 32'(ack_pat[5-i]));
            check($sformatf("%s_valid_e%0d", tag, i), 32'(vec_valid), 32'd0);
        end
        tick();
        check({tag, "_valid_e6"}, 32'(vec_valid), 32'd1);
        check({tag, "_vec_e6"},   32'(vec), 32'(v));
        check({tag, "_ack_e6"},   32'(int_ack), 32'd0);
        tick();
        check({tag, "_valid_e7"}, 32'(vec_valid), 32'd0);
        check({tag, "_take_e7"},  32'(cpu_int_take), 32'd0);
        check({tag, "_vec_e7"},   32'(vec), 32'(v));
        tick();
        check({tag, "_norestart_e8"}, 32'(int_ack), 32'd0);
    endtask

    logic [20:0] ack_s;
    logic [20:0] val_s;

    initial begin
        reset = 1'b1; ce = 1'b1; int_req = 1'b0; int_vector = 8'h00;
        cpu_if = 1'b0; cpu_boundary = 1'b0; vec_ready = 1'b0;
        tick(); tick();
        check("rst_ack",   32'(int_ack), 32'd0);
        check("rst_take",  32'(cpu_int_take), 32'd0);
        check("rst_valid", 32'(vec_valid), 32'd0);
        check("rst_vec",   32'(vec), 32'h00);
`ifdef M107_INTA_ABORT_EN
        check("rst_spur",  32'(spurious), 32'd0);
`endif
        reset = 1'b0;
        tick();

        run_sequence(8'h48, "basic");

        // Interrupts masked: no sequence despite request and boundaries.
        cpu_if = 1'b0; int_req = 1'b1; cpu_boundary = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ifgate_ack_%0d", i), 32'(int_ack), 32'd0);
            check($sformatf("ifgate_take_%0d", i), 32'(cpu_int_take), 32'd0);
        end
        cpu_boundary = 1'b0;
        tick();

        // Back-pressure: CPU withholds ready for 10 cycles.
        cpu_if = 1'b1; vec_ready = 1'b0; int_vector = 8'hA5; cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        check("bp_valid_e6", 32'(vec_valid), 32'd1);
        check("bp_vec_e6",   32'(vec), 32'hA5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_vec_hold_%0d", i), 32'(vec), 32'hA5);
            check($sformatf("bp_take_hold_%0d", i), 32'(cpu_int_take), 32'd1);
            check($sformatf("bp_valid_hold_%0d", i), 32'(vec_valid), 32'd1);
        end
        vec_ready = 1'b1;
        tick();
        check("bp_valid_release", 32'(vec_valid), 32'd0);
        check("bp_take_release",  32'(cpu_int_take), 32'd0);
        check("bp_vec_release",   32'(vec), 32'hA5);
        tick();

        // ce on every 3rd clk: each 2-ce-edge phase spans 6 clk cycles.
        int_vector = 8'h5A;
        for (int c = 0; c < 21; c++) begin
            ce           = (c % 3 == 0);
            cpu_boundary = (c == 0);
            tick();
            ack_s[c] = int_ack;
            val_s[c] = vec_valid;
        end
        ce = 1'b1; cpu_boundary = 1'b0;
        for (int c = 0; c < 21; c++) begin
            logic exp_ack;
            exp_ack = (c <= 5) || (c >= 12 && c <= 17);
            check($sformatf("ce_ack_c%0d", c), 32'(ack_s[c]), 32'(exp_ack));
            check($sformatf("ce_valid_c%0d", c), 32'(val_s[c]), 32'(c >= 18));
        end
        check("ce_vec", 32'(vec), 32'h5A);
        tick();
        check("ce_done_valid", 32'(vec_valid), 32'd0);
        tick();

        // Reset while in ACK2 (after E4), then a fresh sequence.
        int_vector = 8'h77; cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("ack2_in_progress", 32'(int_ack), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_ack",   32'(int_ack), 32'd0);
        check("midrst_take",  32'(cpu_int_take), 32'd0);
        check("midrst_valid", 32'(vec_valid), 32'd0);
        check("midrst_vec",   32'(vec), 32'h00);
        reset = 1'b0;
        tick();
        check("postrst_idle", 32'(int_ack), 32'd0);
        run_sequence(8'h3C, "postrst");

`ifdef M107_INTA_ABORT_EN
        // Drop int_req in GAP: abort at the GAP exit edge (E4).
        int_req = 1'b1; cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        tick(); tick();
        check("abort_gap_ack", 32'(int_ack), 32'd0);
        int_req = 1'b0;
        tick();
        check("abort_e3_spur", 32'(spurious), 32'd0);
        tick();
        check("abort_e4_ack",   32'(int_ack), 32'd0);
        check("abort_e4_take",  32'(cpu_int_take), 32'd0);
        check("abort_e4_spur",  32'(spurious), 32'd1);
        check("abort_e4_valid", 32'(vec_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_after_spur_%0d", i), 32'(spurious), 32'd0);
            check($sformatf("abort_after_ack_%0d", i), 32'(int_ack), 32'd0);
            check($sformatf("abort_after_valid_%0d", i), 32'(vec_valid), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
